uart_rx_frame_parser: RTL and testbench

- Sits directly downstream of the UART receiver.
- Consumes the received byte stream (data_out / data_out_valid / check_flag) and extracts framed packets: HEADER, LEN, LEN payload bytes, CHK.
- Buffers the payload internally and releases it on a valid/ready stream only after LEN, parity and checksum all pass.
- Reports every good or aborted frame to the host logic with status pulses.

---
 rtl/uart_rx_frame_parser.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_frame_parser.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_parser.sv
// Extracts HEADER/LEN/payload/CHK frames from a UART byte stream and releases verified
// payloads on a valid/ready stream. Define UART_PARSER_STATS_EN to add ok/err frame counters.
module uart_rx_frame_parser #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_check_flag,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [2:0]  err_code,
  output logic        busy
`ifdef UART_PARSER_STATS_EN
  ,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
`endif
);
  localparam int unsigned   AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned   TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [2:0] E_LEN     = 3'd1;
  localparam logic [2:0] E_PARITY  = 3'd2;
  localparam logic [2:0] E_CHK     = 3'd3;
  localparam logic [2:0] E_TIMEOUT = 3'd4;
  localparam logic [2:0] E_OVERRUN = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_EMIT} state_t;

  state_t        r_state, w_state_n;
  logic [7:0]    r_len, w_len_n;
  logic [7:0]    r_cnt, w_cnt_n;
  logic [7:0]    r_chk, w_chk_n;
  logic [7:0]    r_rd, w_rd_n;
  logic [TW-1:0] r_tmo, w_tmo_n;
  logic          r_pkt_ok, w_pkt_ok_n;
  logic          r_pkt_err, w_pkt_err_n;
  logic [2:0]    r_err_code, w_err_code_n;
  logic          w_buf_we;
  logic          w_in_frame;
  logic [7:0]    r_buf [MAX_LEN];

  always_comb begin
    w_state_n    = r_state;
    w_len_n      = r_len;
    w_cnt_n      = r_cnt;
    w_chk_n      = r_chk;
    w_rd_n       = r_rd;
    w_tmo_n      = '0;
    w_pkt_ok_n   = 1'b0;
    w_pkt_err_n  = 1'b0;
    w_err_code_n = r_err_code;
    w_buf_we     = 1'b0;
    w_in_frame   = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);

    // Timeout only advances on idle cycles, so an arriving byte always wins over expiry.
    if (w_in_frame && !rx_valid) begin
      if (r_tmo == TMO_LAST) begin
        w_state_n    = S_IDLE;
        w_pkt_err_n  = 1'b1;
        w_err_code_n = E_TIMEOUT;
      end else begin
        w_tmo_n = r_tmo + 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (rx_valid && !rx_check_flag && (rx_data == HEADER)) w_state_n = S_LEN;
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_check_flag) begin
            w_state_n = S_IDLE; w_pkt_err_n = 1'b1; w_err_code_n = E_PARITY;
          end else if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            w_state_n = S_IDLE; w_pkt_err_n = 1'b1; w_err_code_n = E_LEN;
          end else begin
            w_len_n   = rx_data;
            w_chk_n   = rx_data;
            w_cnt_n   = '0;
            w_state_n = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          if (rx_check_flag) begin
            w_state_n = S_IDLE; w_pkt_err_n = 1'b1; w_err_code_n = E_PARITY;
          end else begin
            w_buf_we = 1'b1;
            w_chk_n  = r_chk ^ rx_data;
            w_cnt_n  = r_cnt + 8'd1;
            if ((r_cnt + 8'd1) == r_len) w_state_n = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_check_flag) begin
            w_state_n = S_IDLE; w_pkt_err_n = 1'b1; w_err_code_n = E_PARITY;
          end else if (rx_data == r_chk) begin
            w_state_n = S_EMIT; w_pkt_ok_n = 1'b1; w_rd_n = '0;
          end else begin
            w_state_n = S_IDLE; w_pkt_err_n = 1'b1; w_err_code_n = E_CHK;
          end
        end
      end
      S_EMIT: begin
        if (rx_valid) begin
          w_pkt_err_n = 1'b1; w_err_code_n = E_OVERRUN;
        end
        if (out_ready) begin
          if (r_rd == (r_len - 8'd1)) begin
            w_state_n = S_IDLE; w_rd_n = '0;
          end else begin
            w_rd_n = r_rd + 8'd1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_cnt      <= '0;
      r_chk      <= '0;
      r_rd       <= '0;
      r_tmo      <= '0;
      r_pkt_ok   <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_state    <= w_state_n;
      r_len      <= w_len_n;
      r_cnt      <= w_cnt_n;
      r_chk      <= w_chk_n;
      r_rd       <= w_rd_n;
      r_tmo      <= w_tmo_n;
      r_pkt_ok   <= w_pkt_ok_n;
      r_pkt_err  <= w_pkt_err_n;
      r_err_code <= w_err_code_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_cnt[AW-1:0]] <= rx_data;
  end

  assign out_valid = (r_state == S_EMIT);
  assign out_data  = out_valid ? r_buf[r_rd[AW-1:0]] : '0;
  assign out_last  = out_valid && (r_rd == (r_len - 8'd1));
  assign pkt_ok    = r_pkt_ok;
  assign pkt_err   = r_pkt_err;
  assign err_code  = r_err_code;
  assign busy      = (r_state != S_IDLE);

`ifdef UART_PARSER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (w_pkt_ok_n && (ok_cnt != '1))   ok_cnt  <= ok_cnt + 16'd1;
      if (w_pkt_err_n && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: directed frame table, timeout/backpressure sequences,
// and randomly constructed frames whose outcome is known from how they were built.
module tb_uart_rx_frame_parser;
  localparam int unsigned TMO = 40;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_check_flag = 1'b0, out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, out_last, pkt_ok, pkt_err, busy;
  logic [2:0] err_code;
`ifdef UART_PARSER_STATS_EN
  logic [15:0] ok_cnt, err_cnt;
`endif

  int errors = 0, checks = 0;
  int cyc = 0;
  int         got_ev[$], exp_ev[$], got_cyc[$];
  logic [7:0] got_out[$], exp_out[$];
  logic       got_last[$], exp_last[$];
  int both_viol = 0, okv_viol = 0, stab_viol = 0;
  logic       p_hold = 1'b0, p_last = 1'b0;
  logic [7:0] p_data = '0;

  typedef struct {
    string           name;
    int              n;
    logic [0:7][7:0] b;
    logic [0:7]      pf;
    int              ev;
    int              nout;
    logic [0:2][7:0] o;
  } vec_t;
  vec_t vt[8];

  uart_rx_frame_parser #(.HEADER(8'hA5), .MAX_LEN(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_check_flag(rx_check_flag), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .busy(busy)
`ifdef UART_PARSER_STATS_EN
    , .ok_cnt(ok_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (pkt_ok) got_ev.push_back(0);
      if (pkt_err) got_ev.push_back(int'(err_code));
      if (pkt_ok && pkt_err) both_viol <= both_viol + 1;
      if (pkt_ok && !out_valid) okv_viol <= okv_viol + 1;
      if (p_hold && (!out_valid || out_data !== p_data || out_last !== p_last))
        stab_viol <= stab_viol + 1;
      if (out_valid && out_ready) begin
        got_out.push_back(out_data);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
      end
      p_hold <= out_valid && !out_ready;
      p_data <= out_data;
      p_last <= out_last;
    end else begin
      p_hold <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_q();
    got_ev.delete(); exp_ev.delete(); got_cyc.delete();
    got_out.delete(); exp_out.delete(); got_last.delete(); exp_last.delete();
  endtask

  task automatic cmp_queues(input string tag);
    chk({tag, " event count"}, got_ev.size(), exp_ev.size());
    for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
      chk({tag, " event"}, got_ev[i], exp_ev[i]);
    chk({tag, " out count"}, got_out.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++) begin
      chk({tag, " out_data"}, got_out[i], exp_out[i]);
      chk({tag, " out_last"}, got_last[i], exp_last[i]);
    end
    clear_q();
  endtask

  task automatic send(input logic [7:0] b, input logic pf);
    rx_data = b; rx_valid = 1'b1; rx_check_flag = pf;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_check_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle(input bit rnd_ready, input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    chk({tag, " busy bound"}, n < 500, 1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " busy idle"}, busy, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_last"}, out_last, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " pkt_ok"}, pkt_ok, 0);
    chk({tag, " pkt_err"}, pkt_err, 0);
    chk({tag, " err_code"}, err_code, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  initial begin
    int kind, n, len, p, k, bad;
    logic [7:0] b, c;
    bit pb;
    logic [7:0] fr[$];
    bit pfq[$];

    vt[0] = '{"good",       6, 64'hA503112233030000, 8'b00000000,  0, 3, 24'h112233};
    vt[1] = '{"bad_chk",    5, 64'hA502102000000000, 8'b00000000,  3, 0, 24'h000000};
    vt[2] = '{"len_zero",   2, 64'hA500000000000000, 8'b00000000,  1, 0, 24'h000000};
    vt[3] = '{"len_17",     2, 64'hA511000000000000, 8'b00000000,  1, 0, 24'h000000};
    vt[4] = '{"len_one",    4, 64'hA5017E7F00000000, 8'b00000000,  0, 1, 24'h7E0000};
    vt[5] = '{"idle_noise", 2, 64'h00FF000000000000, 8'b11000000, -1, 0, 24'h000000};
    vt[6] = '{"parity",     3, 64'hA502440000000000, 8'b00100000,  2, 0, 24'h000000};
    vt[7] = '{"resync",     5, 64'hA502A55AFD000000, 8'b00000000,  0, 2, 24'hA55A00};

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
`ifdef UART_PARSER_STATS_EN
    chk("reset ok_cnt", ok_cnt, 0);
    chk("reset err_cnt", err_cnt, 0);
`endif
    rst_n = 1'b1;
    idle(1);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vt[v].n; i++) send(vt[v].b[i], vt[v].pf[i]);
      if (vt[v].ev >= 0) exp_ev.push_back(vt[v].ev);
      for (int i = 0; i < vt[v].nout; i++) begin
        exp_out.push_back(vt[v].o[i]);
        exp_last.push_back(i == vt[v].nout - 1);
      end
      settle(1'b0, vt[v].name);
      if (vt[v].nout > 1 && got_cyc.size() == vt[v].nout)
        chk({vt[v].name, " throughput"}, got_cyc[vt[v].nout-1] - got_cyc[0], vt[v].nout - 1);
      cmp_queues(vt[v].name);
    end

    // timeout fires on the cycle after TMO idle cycles
    send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'h01, 1'b0);
    k = 0;
    for (int i = 1; i <= int'(TMO) + 10; i++) begin
      @(negedge clk);
      if (pkt_err && k == 0) k = i;
    end
    @(posedge clk); #1;
    chk("timeout cycle", k, TMO + 1);
    chk("timeout busy", busy, 0);
    exp_ev.push_back(4);
    cmp_queues("timeout");

    // next byte lands exactly on the expiry cycle
    send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'h01, 1'b0);
    idle(TMO - 1);
    send(8'h02, 1'b0); send(8'h01, 1'b0);
    exp_ev.push_back(0);
    exp_out.push_back(8'h01); exp_last.push_back(1'b0);
    exp_out.push_back(8'h02); exp_last.push_back(1'b1);
    settle(1'b0, "expiry_tie");
    cmp_queues("expiry_tie");

    // reset mid-frame discards the partial frame
    send(8'hA5, 1'b0); send(8'h03, 1'b0); send(8'h11, 1'b0);
    rst_n = 1'b0;
    idle(1);
    check_idle_outputs("midreset");
    rst_n = 1'b1;
    idle(1);
    clear_q();
    send(8'h33, 1'b0); send(8'h44, 1'b0);
    settle(1'b0, "midreset_tail");
    cmp_queues("midreset_tail");

    for (int t = 0; t < 200; t++) begin
      fr.delete(); pfq.delete();
      kind = $urandom_range(0, 4);
      if (kind == 4) begin
        n = $urandom_range(1, 4);
        repeat (n) begin
          b = 8'($urandom);
          pb = 1'($urandom_range(0, 1));
          if (b == 8'hA5 && !pb) b = 8'h5A;
          fr.push_back(b); pfq.push_back(pb);
        end
      end else begin
        if (kind == 2) len = $urandom_range(0, 1) ? 0 : $urandom_range(17, 255);
        else           len = $urandom_range(1, 16);
        fr.push_back(8'hA5); fr.push_back(8'(len));
        c = 8'(len);
        if (kind != 2) begin
          for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            fr.push_back(b);
            c ^= b;
          end
          fr.push_back(kind == 1 ? (c ^ 8'($urandom_range(1, 255))) : c);
        end
        for (int i = 0; i < fr.size(); i++) pfq.push_back(1'b0);
        if (kind == 3) begin
          p = $urandom_range(1, fr.size() - 1);
          pfq[p] = 1'b1;
          while (fr.size() > p + 1) begin
            void'(fr.pop_back());
            void'(pfq.pop_back());
          end
        end
        case (kind)
          0: begin
            exp_ev.push_back(0);
            for (int i = 2; i <= len + 1; i++) begin
              exp_out.push_back(fr[i]);
              exp_last.push_back(i == len + 1);
            end
          end
          1: exp_ev.push_back(3);
          2: exp_ev.push_back(1);
          default: exp_ev.push_back(2);
        endcase
      end
      for (int i = 0; i < fr.size(); i++) begin
        send(fr[i], pfq[i]);
        idle($urandom_range(0, 3));
      end
      settle(1'b1, "rand");
      cmp_queues("rand");
    end

    // backpressure with an overrun byte during the stall
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    clear_q();
    out_ready = 1'b0;
    send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'h13, 1'b0);
    exp_ev.push_back(0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(out_valid && out_data == 8'hAA && !out_last)) bad++;
    end
    @(posedge clk); #1;
    send(8'h55, 1'b0);
    exp_ev.push_back(5);
    repeat (10) begin
      @(negedge clk);
      if (!(out_valid && out_data == 8'hAA && !out_last)) bad++;
    end
    @(posedge clk); #1;
    chk("stall hold", bad, 0);
    chk("overrun busy", busy, 1);
    chk("overrun err_code", err_code, 5);
    out_ready = 1'b1;
    exp_out.push_back(8'hAA); exp_last.push_back(1'b0);
    exp_out.push_back(8'hBB); exp_last.push_back(1'b1);
    settle(1'b0, "overrun");
    cmp_queues("overrun");
`ifdef UART_PARSER_STATS_EN
    chk("stats ok_cnt", ok_cnt, 1);
    chk("stats err_cnt", err_cnt, 1);
`endif

    chk("ok/err same cycle", both_viol, 0);
    chk("pkt_ok without out_valid", okv_viol, 0);
    chk("out stable under stall", stab_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
